// File: rtl/pc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_unit : program counter with relative/absolute jumps, traps, and a     |
// |           circular return-address stack; misaligned targets never commit |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pc_unit #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_VEC  = '0,
   parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'('h100),
   parameter int              STEP       = 4,
   parameter int              ALIGN_BITS = 2,
   parameter int              RAS_DEPTH  = 4
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic [2:0]      pc_ctl,
   input  logic [XLEN-1:0] offset_in,
   input  logic [XLEN-1:0] target_in,
   output logic [XLEN-1:0] addr_out,
   output logic [XLEN-1:0] link_out,
   output logic            misaligned,
   output logic [XLEN-1:0] bad_addr,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            ras_overflow,
   output logic            ras_underflow
);

   localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam logic [XLEN-1:0] c_ALIGN_MASK = {XLEN{1'b1}} >> (XLEN - ALIGN_BITS);

   localparam logic [2:0] c_CMD_HOLD = 3'd0;
   localparam logic [2:0] c_CMD_STEP = 3'd1;
   localparam logic [2:0] c_CMD_REL  = 3'd2;
   localparam logic [2:0] c_CMD_ABS  = 3'd3;
   localparam logic [2:0] c_CMD_CALL = 3'd4;
   localparam logic [2:0] c_CMD_RET  = 3'd5;
   localparam logic [2:0] c_CMD_TRAP = 3'd6;

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_ras [RAS_DEPTH];
   logic [PW-1:0]   r_wp;
   logic [CW-1:0]   r_cnt;
   logic            r_mis;
   logic [XLEN-1:0] r_bad;
   logic            r_ovf;
   logic            r_unf;

   logic [XLEN-1:0] w_link;
   logic [XLEN-1:0] w_nxt;
   logic [XLEN-1:0] w_top;
   logic            w_chk;
   logic            w_mis;
   logic            w_empty;
   logic            w_full;
   logic            w_push;
   logic            w_pop;
   logic            w_unf;

   assign w_link  = r_pc + XLEN'(STEP);
   assign w_empty = (r_cnt == '0);
   assign w_full  = (r_cnt == CW'(RAS_DEPTH));
   // r_wp is the next free slot, so the newest entry sits just below it
   assign w_top   = r_ras[r_wp - PW'(1)];

   always_comb begin
      w_nxt = r_pc;
      w_chk = 1'b0;
      case (pc_ctl)
         c_CMD_STEP: w_nxt = w_link;
         c_CMD_REL:  begin w_nxt = r_pc + offset_in; w_chk = 1'b1; end
         c_CMD_ABS:  begin w_nxt = target_in;        w_chk = 1'b1; end
         c_CMD_CALL: begin w_nxt = r_pc + offset_in; w_chk = 1'b1; end
         c_CMD_RET:  begin w_nxt = w_empty ? TRAP_VEC : w_top; w_chk = 1'b1; end
         c_CMD_TRAP: w_nxt = TRAP_VEC;
         default:    w_nxt = r_pc;
      endcase
   end

   assign w_mis  = w_chk && ((w_nxt & c_ALIGN_MASK) != '0);
   assign w_push = (pc_ctl == c_CMD_CALL) && !w_mis;
   assign w_pop  = (pc_ctl == c_CMD_RET) && !w_mis && !w_empty;
   assign w_unf  = (pc_ctl == c_CMD_RET) && !w_mis && w_empty;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_pc  <= RESET_VEC;
         r_wp  <= '0;
         r_cnt <= '0;
         r_mis <= 1'b0;
         r_bad <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
      end else begin
         r_mis <= w_mis;
         r_ovf <= w_push && w_full;
         r_unf <= w_unf;
         if (w_mis) r_bad <= w_nxt;
         else       r_pc  <= w_nxt;
         // A push while full overwrites the oldest slot, which is the one r_wp points at
         if (w_push) begin
            r_ras[r_wp] <= w_link;
            r_wp        <= r_wp + PW'(1);
            if (!w_full) r_cnt <= r_cnt + CW'(1);
         end else if (w_pop) begin
            r_wp  <= r_wp - PW'(1);
            r_cnt <= r_cnt - CW'(1);
         end
      end
   end

   assign addr_out      = r_pc;
   assign link_out      = w_link;
   assign misaligned    = r_mis;
   assign bad_addr      = r_bad;
   assign ras_empty     = w_empty;
   assign ras_full      = w_full;
   assign ras_overflow  = r_ovf;
   assign ras_underflow = r_unf;

endmodule
`default_nettype wire
